// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store control stage: memory op codes,
// funct3 encodings, fault cause codes and FSM states.
package lsu_ctrl_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_XLEN   = 32;

  // Memory op codes: bit2 set means store (or idle), bits[1:0] give the size.
  // Size 11 does not exist, so 111 doubles as the no-write idle code.
  typedef enum logic [2:0] {
    OP_LOAD_BYTE   = 3'b000,
    OP_LOAD_HALF   = 3'b001,
    OP_LOAD_WORD   = 3'b010,
    OP_STORE_BYTE  = 3'b100,
    OP_STORE_HALF  = 3'b101,
    OP_STORE_WORD  = 3'b110,
    OP_IDLE        = 3'b111
  } mem_op_e;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_MISALIGNED = 2'b01,
    CAUSE_RANGE      = 2'b10,
    CAUSE_ILLEGAL    = 2'b11
  } err_cause_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } lsu_state_e;

  // Memory op for a legal request; funct3[2] (unsigned) does not affect size.
  function automatic mem_op_e op_for(input logic load, input logic [2:0] funct3);
    return mem_op_e'({~load, funct3[1:0]});
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request channel from the execute stage into the load/store control stage.
interface lsu_ctrl_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_load;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_wdata;
  logic [4:0]      ex_rd;

  // Execute stage drives requests
  modport master (
    output ex_valid, ex_load, ex_funct3, ex_addr, ex_wdata, ex_rd,
    input  ex_ready
  );

  // Load/store control stage consumes them
  modport slave (
    input  ex_valid, ex_load, ex_funct3, ex_addr, ex_wdata, ex_rd,
    output ex_ready
  );
endinterface

// File: rtl/lsu_ctrl_check.sv
// Combinational legality checker: illegal funct3 beats out-of-range, which
// beats misalignment. Only the address bits that matter are passed in.
module lsu_ctrl_check
  import lsu_ctrl_pkg::*;
#(
  parameter int HI_W = 21
) (
  input  logic            i_load,
  input  logic [2:0]      i_funct3,
  input  logic [HI_W-1:0] i_addr_hi,
  input  logic [1:0]      i_addr_lo,
  output logic            o_fault,
  output err_cause_e      o_cause
);

  logic w_illegal;
  logic w_range;
  logic w_misaligned;

  // Stores have no unsigned variants; 011 and 11x are never valid
  assign w_illegal = (!i_load && i_funct3[2]) ||
                     (i_funct3 == 3'b011) ||
                     (i_funct3[2:1] == 2'b11);

  // Anything above the data memory window is out of range
  assign w_range = |i_addr_hi;

  // Halfwords need even addresses, words need 4-byte alignment
  assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));

  // Priority encode the first failing check
  always_comb begin
    o_fault = 1'b1;
    o_cause = CAUSE_NONE;
    if (w_illegal) begin
      o_cause = CAUSE_ILLEGAL;
    end else if (w_range) begin
      o_cause = CAUSE_RANGE;
    end else if (w_misaligned) begin
      o_cause = CAUSE_MISALIGNED;
    end else begin
      o_fault = 1'b0;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage ahead of data memory: checks and registers requests
// (S1), tracks the load whose data is returning (S2), zero-extends unsigned
// loads, reports faults and raises the load-use hazard stall toward decode.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int XLEN   = DEF_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  lsu_ctrl_if.slave         ex,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  output logic [2:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_stall,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              hazard_stall,
  output logic              err_valid,
  output logic [1:0]        err_cause,
  output logic [XLEN-1:0]   err_addr,
  input  logic              err_ack
);

  lsu_state_e        r_state;
  logic              r_err_valid;
  err_cause_e        r_err_cause;
  logic [XLEN-1:0]   r_err_addr;

  logic              r_s1_valid;
  logic              r_s1_load;
  logic [2:0]        r_s1_funct3;
  logic [4:0]        r_s1_rd;
  mem_op_e           r_mem_op;
  logic              r_mem_stall;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;

  logic              r_s2_valid;
  logic [2:0]        r_s2_funct3;
  logic [4:0]        r_s2_rd;

  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;

  logic              w_ready;
  logic              w_accept;
  logic              w_fault;
  err_cause_e        w_cause;
  logic              w_take;
  logic              w_trap;
  logic [XLEN-1:0]   w_ext;
  logic              w_s1_hit;
  logic              w_s2_hit;

  lsu_ctrl_check #(
    .HI_W (XLEN - ADDR_W)
  ) u_check (
    .i_load    (ex.ex_load),
    .i_funct3  (ex.ex_funct3),
    .i_addr_hi (ex.ex_addr[XLEN-1:ADDR_W]),
    .i_addr_lo (ex.ex_addr[1:0]),
    .o_fault   (w_fault),
    .o_cause   (w_cause)
  );

  assign w_ready     = (r_state == ST_RUN);
  assign ex.ex_ready = w_ready;
  assign w_accept    = ex.ex_valid && w_ready;
  assign w_take      = w_accept && !w_fault;
  assign w_trap      = w_accept && w_fault;

  // Fault FSM: a faulting request parks the stage in ERR until acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_err_valid <= 1'b0;
      r_err_cause <= CAUSE_NONE;
      r_err_addr  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_trap) begin
            r_state     <= ST_ERR;
            r_err_valid <= 1'b1;
            r_err_cause <= w_cause;
            r_err_addr  <= ex.ex_addr;
          end
        end
        ST_ERR: begin
          if (err_ack) begin
            r_state     <= ST_RUN;
            r_err_valid <= 1'b0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // S1: request register that drives the memory for one cycle per access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_load   <= 1'b0;
      r_s1_funct3 <= '0;
      r_s1_rd     <= '0;
      r_mem_op    <= OP_IDLE;
      r_mem_stall <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_s1_valid  <= w_take;
      r_mem_stall <= !w_take;
      r_mem_op    <= w_take ? op_for(ex.ex_load, ex.ex_funct3) : OP_IDLE;
      if (w_take) begin
        r_s1_load   <= ex.ex_load;
        r_s1_funct3 <= ex.ex_funct3;
        r_s1_rd     <= ex.ex_rd;
        r_mem_addr  <= ex.ex_addr[ADDR_W-1:0];
        r_mem_wdata <= ex.ex_wdata;
      end
    end
  end

  // S2: the load whose read data is on mem_rdata this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_funct3 <= '0;
      r_s2_rd     <= '0;
    end else begin
      r_s2_valid <= r_s1_valid && r_s1_load;
      if (r_s1_valid && r_s1_load) begin
        r_s2_funct3 <= r_s1_funct3;
        r_s2_rd     <= r_s1_rd;
      end
    end
  end

  // Memory already sign-extends; unsigned loads clear the upper bits here
  always_comb begin
    w_ext = mem_rdata;
    case (r_s2_funct3)
      F3_BU:   w_ext = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
      F3_HU:   w_ext = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  // Writeback register: one-cycle valid pulse per completed load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_wb_rd   <= r_s2_rd;
        r_wb_data <= w_ext;
      end
    end
  end

  // Load-use: decode waits while its sources are still being loaded (x0 exempt)
  assign w_s1_hit = r_s1_valid && r_s1_load && (r_s1_rd != 5'd0) &&
                    ((r_s1_rd == id_rs1) || (r_s1_rd == id_rs2));
  assign w_s2_hit = r_s2_valid && (r_s2_rd != 5'd0) &&
                    ((r_s2_rd == id_rs1) || (r_s2_rd == id_rs2));
  assign hazard_stall = w_s1_hit || w_s2_hit;

  assign mem_op    = r_mem_op;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_stall = r_mem_stall;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign err_valid = r_err_valid;
  assign err_cause = r_err_cause;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, extension, faults, hazard, reset.
module tb_lsu_ctrl;

  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_LB   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_IDLE = 3'b111;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [2:0]  mem_op;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        hazard_stall;
  logic        err_valid;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;
  logic        err_ack;

  logic        use_model;
  logic [31:0] rdata_drv;
  logic [31:0] model_mem [0:511];
  logic [31:0] model_q;

  int checks;
  int failures;

  lsu_ctrl_if #(.XLEN(32)) ex_if ();

  lsu_ctrl #(.ADDR_W(11), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex           (ex_if),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_stall    (mem_stall),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .hazard_stall (hazard_stall),
    .err_valid    (err_valid),
    .err_cause    (err_cause),
    .err_addr     (err_addr),
    .err_ack      (err_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory with registered read, used for the store-then-load step
  always @(posedge clk) begin
    if (!mem_stall) begin
      if (mem_op == OP_SW) model_mem[mem_addr[10:2]] <= mem_wdata;
      model_q <= model_mem[mem_addr[10:2]];
    end
  end
  assign mem_rdata = use_model ? model_q : rdata_drv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge, then withdraw it
  task automatic send(input logic load, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd);
    ex_if.ex_valid  = 1'b1;
    ex_if.ex_load   = load;
    ex_if.ex_funct3 = f3;
    ex_if.ex_addr   = addr;
    ex_if.ex_wdata  = wdata;
    ex_if.ex_rd     = rd;
    tick();
    ex_if.ex_valid  = 1'b0;
  endtask

  task automatic ack();
    err_ack = 1'b1;
    tick();
    err_ack = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    id_rs1 = 5'd0;
    id_rs2 = 5'd0;
    err_ack = 1'b0;
    use_model = 1'b0;
    rdata_drv = 32'h0;
    ex_if.ex_valid = 1'b0;
    ex_if.ex_load = 1'b0;
    ex_if.ex_funct3 = 3'b000;
    ex_if.ex_addr = 32'h0;
    ex_if.ex_wdata = 32'h0;
    ex_if.ex_rd = 5'd0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_op", {29'b0, mem_op}, {29'b0, OP_IDLE});
    chk("rst_mem_stall", {31'b0, mem_stall}, 32'd1);
    chk("rst_mem_addr", {21'b0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_wb", {26'b0, wb_valid, wb_rd}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_err", {29'b0, hazard_stall, err_cause}, 32'h0);
    chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_ex_ready", {31'b0, ex_if.ex_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // LW 0x104 -> DEADBEEF, writeback two edges after accept
    send(1'b1, 3'b010, 32'h104, 32'h0, 5'd7);
    chk("lw_op", {29'b0, mem_op}, {29'b0, OP_LW});
    chk("lw_addr", {21'b0, mem_addr}, 32'h104);
    chk("lw_stall", {31'b0, mem_stall}, 32'd0);
    rdata_drv = 32'hDEADBEEF;
    tick();
    chk("lw_idle_after", {31'b0, mem_stall}, 32'd1);
    chk("lw_wb_early", {31'b0, wb_valid}, 32'd0);
    tick();
    chk("lw_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    chk("lw_wb_rd", {27'b0, wb_rd}, 32'd7);
    tick();
    chk("lw_wb_pulse", {31'b0, wb_valid}, 32'd0);

    // LBU then LB back-to-back at 0x401, memory returns sign-extended 0x80
    rdata_drv = 32'hFFFFFF80;
    send(1'b1, 3'b100, 32'h401, 32'h0, 5'd1);
    chk("lbu_op", {29'b0, mem_op}, {29'b0, OP_LB});
    chk("lbu_addr", {21'b0, mem_addr}, 32'h401);
    send(1'b1, 3'b000, 32'h401, 32'h0, 5'd2);
    chk("lb_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("lbu_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("lbu_wb_data", wb_data, 32'h00000080);
    tick();
    chk("lb_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);
    chk("lb_wb_rd", {27'b0, wb_rd}, 32'd2);
    tick();

    // SH at 0x003: misaligned, no access, stage blocks until ack
    send(1'b0, 3'b001, 32'h3, 32'hABCD, 5'd0);
    chk("sh_stall", {31'b0, mem_stall}, 32'd1);
    chk("sh_err_valid", {31'b0, err_valid}, 32'd1);
    chk("sh_err_cause", {30'b0, err_cause}, 32'd1);
    chk("sh_err_addr", err_addr, 32'h3);
    chk("sh_ex_ready", {31'b0, ex_if.ex_ready}, 32'd0);
    ex_if.ex_valid = 1'b1;
    ex_if.ex_load = 1'b1;
    ex_if.ex_funct3 = 3'b010;
    ex_if.ex_addr = 32'h20;
    ex_if.ex_rd = 5'd3;
    tick();
    tick();
    chk("err_blocks", {31'b0, mem_stall}, 32'd1);
    chk("err_holds", {31'b0, err_valid}, 32'd1);
    err_ack = 1'b1;
    tick();
    err_ack = 1'b0;
    chk("ack_clears", {31'b0, err_valid}, 32'd0);
    chk("ack_ready", {31'b0, ex_if.ex_ready}, 32'd1);
    chk("ack_no_accept", {31'b0, mem_stall}, 32'd1);
    tick();
    ex_if.ex_valid = 1'b0;
    chk("post_ack_stall", {31'b0, mem_stall}, 32'd0);
    chk("post_ack_addr", {21'b0, mem_addr}, 32'h20);
    tick();
    tick();
    tick();

    // Out-of-range and illegal encodings
    send(1'b1, 3'b010, 32'h00001000, 32'h0, 5'd4);
    chk("range_cause", {30'b0, err_cause}, 32'd2);
    chk("range_addr", err_addr, 32'h00001000);
    chk("range_stall", {31'b0, mem_stall}, 32'd1);
    ack();
    send(1'b0, 3'b100, 32'h10, 32'h0, 5'd0);
    chk("sbu_cause", {30'b0, err_cause}, 32'd3);
    ack();
    send(1'b0, 3'b101, 32'h1001, 32'h0, 5'd0);
    chk("illegal_prio", {30'b0, err_cause}, 32'd3);
    ack();
    send(1'b1, 3'b010, 32'h102, 32'h0, 5'd4);
    chk("lw_misaligned", {30'b0, err_cause}, 32'd1);
    ack();
    tick();

    // Fault right behind an accepted load: the load still writes back
    rdata_drv = 32'hA5A5A5A5;
    send(1'b1, 3'b010, 32'h40, 32'h0, 5'd6);
    send(1'b1, 3'b011, 32'h44, 32'h0, 5'd8);
    chk("mix_err_valid", {31'b0, err_valid}, 32'd1);
    chk("mix_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    chk("mix_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("mix_wb_data", wb_data, 32'hA5A5A5A5);
    chk("mix_wb_rd", {27'b0, wb_rd}, 32'd6);
    ack();
    tick();

    // Load-use hazard on rd=5, none for rd=x0
    id_rs2 = 5'd5;
    chk("haz_idle", {31'b0, hazard_stall}, 32'd0);
    send(1'b1, 3'b010, 32'h8, 32'h0, 5'd5);
    chk("haz_s1", {31'b0, hazard_stall}, 32'd1);
    tick();
    chk("haz_s2", {31'b0, hazard_stall}, 32'd1);
    tick();
    chk("haz_clear", {31'b0, hazard_stall}, 32'd0);
    id_rs1 = 5'd0;
    id_rs2 = 5'd0;
    send(1'b1, 3'b010, 32'h8, 32'h0, 5'd0);
    chk("haz_x0_s1", {31'b0, hazard_stall}, 32'd0);
    tick();
    chk("haz_x0_s2", {31'b0, hazard_stall}, 32'd0);
    tick();
    tick();

    // SW 0x10 then LW 0x10 back-to-back through the memory model
    use_model = 1'b1;
    send(1'b0, 3'b010, 32'h10, 32'h12345678, 5'd0);
    chk("sw_op", {29'b0, mem_op}, {29'b0, OP_SW});
    chk("sw_wdata", mem_wdata, 32'h12345678);
    chk("sw_addr", {21'b0, mem_addr}, 32'h10);
    send(1'b1, 3'b010, 32'h10, 32'h0, 5'd9);
    chk("rd_op", {29'b0, mem_op}, {29'b0, OP_LW});
    tick();
    chk("rd_wb_early", {31'b0, wb_valid}, 32'd0);
    tick();
    chk("rd_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("rd_wb_data", wb_data, 32'h12345678);
    chk("rd_wb_rd", {27'b0, wb_rd}, 32'd9);
    tick();

    // Reset while a load sits in S1
    send(1'b1, 3'b010, 32'h14, 32'h0, 5'd4);
    chk("rst_mid_s1", {31'b0, mem_stall}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_stall", {31'b0, mem_stall}, 32'd1);
    chk("rst_mid_op", {29'b0, mem_op}, {29'b0, OP_IDLE});
    chk("rst_mid_addr", {21'b0, mem_addr}, 32'h0);
    chk("rst_mid_wdata", mem_wdata, 32'h0);
    chk("rst_mid_wb_data", wb_data, 32'h0);
    chk("rst_mid_wb_valid", {31'b0, wb_valid}, 32'd0);
    tick();
    chk("rst_mid_no_wb1", {31'b0, wb_valid}, 32'd0);
    tick();
    chk("rst_mid_no_wb2", {31'b0, wb_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage that sits directly upstream of the data memory stage in the RISC-V MEM pipeline stage.
- Accepts load/store requests from the execute stage and checks alignment, range and funct3 legality.
- Registers each legal request and drives the memory op_code/address/write-data/stall inputs.
- Tracks the memory's one-cycle read latency, applies zero-extension for LBU/LHU, returns load results to writeback, and raises a load-use hazard stall toward decode.

Parameters:
- ADDR_W, 11, width of memory byte address presented to data memory (2 KB space, bit 10 selects bank).
- XLEN, 32, register/data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents a request
- ex_ready  out  1  request accepted on clk edge when ex_valid&ex_ready
- ex_load  in  1  request is a load (else store)
- ex_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ex_addr  in  XLEN  effective byte address
- ex_wdata  in  XLEN  store data (rs2)
- ex_rd  in  5  load destination register
- id_rs1, id_rs2  in  5 each  source registers of instruction in decode
- mem_op  out  3  op_code to data memory (LoadByte..StoreWord, idle code)
- mem_addr  out  ADDR_W  rwaddr to data memory
- mem_wdata  out  XLEN  wdata to data memory
- mem_stall  out  1  1 = no access this cycle (memory keeps both cen high)
- mem_rdata  in  XLEN  rdata from data memory (lane-selected, sign-extended)
- wb_valid  out  1  load result valid, one-cycle pulse
- wb_rd  out  5  destination of wb_data
- wb_data  out  XLEN  final load value
- hazard_stall  out  1  decode must stall (load-use)
- err_valid  out  1  fault pending
- err_cause  out  2  01 misaligned, 10 out-of-range, 11 illegal funct3
- err_addr  out  XLEN  faulting address
- err_ack  in  1  clears fault

Behaviour:
- Reset (sync, rst=1 at edge):
  - All valid flags cleared; FSM to RUN.
  - mem_op = idle code (bit2=1, no write); mem_stall=1; mem_addr=0; mem_wdata=0.
  - wb_valid=0, wb_rd=0, wb_data=0, hazard_stall=0, err_valid=0, err_cause=0, err_addr=0.
  - Reset mid-operation discards in-flight requests; no wb_valid follows.
- Pipeline:
  - S1 is the request register that drives memory.
  - S2 tracks a load whose data arrives during that cycle.
  - Accepted at edge E0 -> S1 drives mem_* during E0..E1 with mem_stall=0 -> memory samples at E1.
  - For loads, mem_rdata is valid E1..E2; wb_data/wb_rd captured at E2; wb_valid high for the cycle after E2.
  - Load latency: two edges from acceptance. Back-to-back accepts allowed, one per cycle, full throughput.
- Stores: memory writes at E1; no wb_valid.
- S1 empty -> mem_stall=1, mem_op=idle.
- op mapping:
  - Loads: funct3[1:0]=00 -> LoadByte, 01 -> LoadHalfWord, 10 -> LoadWord.
  - Stores use the Store counterparts.
  - mem_addr = ex_addr[ADDR_W-1:0].
  - mem_wdata = ex_wdata unshifted; the memory does the lane placement.
- Extension: if S2 funct3 is 100, wb_data = {24'b0, mem_rdata[7:0]}; if 101, wb_data = {16'b0, mem_rdata[15:0]}; otherwise wb_data = mem_rdata.
- Checks, evaluated at acceptance, in priority order:
  - Illegal: store with funct3[2]=1, or any funct3 of 011/11x.
  - Out-of-range: ex_addr[XLEN-1:ADDR_W] != 0.
  - Misaligned: H with addr[0]=1, or W with addr[1:0] != 0.
- Faulting request handling:
  - Never reaches S1.
  - FSM goes RUN -> ERR; err_valid=1; err_cause and err_addr are latched.
- ERR state:
  - ex_ready=0; in-flight S1/S2 requests still complete normally.
  - err_ack=1 -> RUN next edge; err_valid=0.
  - err_ack in RUN is ignored.
- ex_ready = (state==RUN).
- hazard_stall (combinational):
  - Asserts when S1 holds a valid load with rd != 0 and rd equals id_rs1 or id_rs2.
  - Asserts likewise for S2.
  - Never asserts for rd=x0.
- Simultaneous fault and in-flight load: the writeback of the earlier load still occurs.

Decomposition:
- Shared header mem.vh:
  - op_code macros (LoadByte, LoadHalfWord, LoadWord, StoreByte, StoreHalfWord, StoreWord, idle code).
  - Add funct3 constants and err_cause codes.
- One natural sub-module: lsu_check, the combinational legality/alignment/range checker producing fault and cause.
- Pipeline registers, FSM and extension logic stay in lsu_ctrl.

Test Plan:
- LW addr 0x104 with mem_rdata=0xDEADBEEF returned -> mem_op=LoadWord, mem_addr=0x104, mem_stall=0 one cycle after accept; wb_valid two edges after accept, wb_data=0xDEADBEEF, wb_rd=ex_rd.
- LBU addr 0x401 with mem_rdata=0xFFFFFF80 -> wb_data=0x00000080; LB at the same address -> wb_data=0xFFFFFF80.
- SH addr 0x003 -> no memory access (mem_stall=1), err_valid=1, err_cause=01, err_addr=0x3, ex_ready=0 until err_ack; next request is accepted after ack.
- LW addr 0x00001000 -> err_cause=10; SB with funct3=100 -> err_cause=11.
- LW rd=5 accepted, decode id_rs2=5 -> hazard_stall=1 for two cycles, then 0; LW rd=0 with id_rs1=0 -> hazard_stall stays 0.
- Back-to-back SW 0x10 data 0x12345678 then LW 0x10 -> memory write at E1, read at E2, wb_data=0x12345678; rst asserted while a load is in S1 -> no wb_valid, outputs return to reset values.
